// File: rtl/fetch_pkg.sv
// Shared state encoding and default widths for the instruction fetch controller.
package fetch_pkg;

  localparam int FETCH_AW = 8;
  localparam int FETCH_DW = 16;
  localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, redirect load (highest priority), increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  // Wrap at 2^AW falls out of the natural AW-bit add.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, decode hand-off, redirect handling.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
//
// state | meaning
// IDLE  | no request pending; waits for halt low
// REQ   | imem_req_valid high, imem_addr = pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | id_valid high with a captured word, waiting for id_ready
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW,
  parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   fetch_count,
  output logic [15:0]   discard_count
`endif
);

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] REQ  = S_REQ;
  localparam logic [1:0] WAIT = S_WAIT;
  localparam logic [1:0] HOLD = S_HOLD;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          discard;
  logic [AW-1:0] req_addr;

  logic accept;
  logic rsp_in_wait;
  logic drop;
  logic capture;
  logic hold_release;
  logic resume_state_is_req;

  assign accept       = (state == REQ) && imem_req_ready;
  assign rsp_in_wait  = (state == WAIT) && imem_rsp_valid;
  // A redirect arriving together with the response makes that response stale too.
  assign drop         = rsp_in_wait && (discard || redirect_valid);
  assign capture      = rsp_in_wait && !drop;
  assign hold_release = (state == HOLD) && (id_ready || redirect_valid);
  assign resume_state_is_req = !halt;

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .inc         (accept),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!halt) state_nxt = REQ;
      end
      REQ: begin
        if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (capture) begin
          state_nxt = HOLD;
        end else if (drop) begin
          state_nxt = resume_state_is_req ? REQ : IDLE;
        end
      end
      HOLD: begin
        if (hold_release) state_nxt = resume_state_is_req ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      discard  <= 1'b0;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr <= pc;
        discard  <= redirect_valid;
      end else if (state == WAIT) begin
        // Any response in WAIT consumes the outstanding request, so the flag never survives it.
        discard <= imem_rsp_valid ? 1'b0 : (discard || redirect_valid);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= RESET_PC;
    end else if (capture) begin
      id_valid <= 1'b1;
      id_instr <= imem_rsp_data;
      id_pc    <= req_addr;
    end else if (hold_release) begin
      id_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_event;

  assign fetch_event = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count   <= 16'h0000;
      discard_count <= 16'h0000;
    end else begin
      if (fetch_event && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'h0001;
      end
      if (drop && (discard_count != 16'hFFFF)) begin
        discard_count <= discard_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: vector table, directed corner sequences, random run vs model.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [7:0]  imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic [7:0]  pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] discard_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .pc             (pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .discard_count  (discard_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic        rv;
    logic [7:0]  rpc;
    logic        rdy;
    logic        rsp;
    logic [15:0] data;
    logic        idr;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_idv;
    logic [7:0]  e_idpc;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t vt[10];

  // Reference model state (transaction view: requesting / in flight / delivered slot).
  logic        m_req;
  logic        m_fly;
  logic        m_stale;
  logic [7:0]  m_fly_addr;
  logic        m_slot;
  logic [7:0]  m_slot_pc;
  logic [15:0] m_slot_instr;
  logic [7:0]  m_pc;
  int          exp_fetch;
  int          exp_disc;

  logic        mem_pend;
  logic [7:0]  mem_addr;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s got %0h expected %0h", tag, field, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic rv, input logic [7:0] rpc, input logic rdy,
                       input logic rsp, input logic [15:0] dat, input logic idr);
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = dat;
    id_ready       = idr;
  endtask

  task automatic expect_out(input string tag, input logic e_req, input logic [7:0] e_addr,
                            input logic e_idv, input logic [7:0] e_idpc, input logic [15:0] e_instr,
                            input logic [7:0] e_pc);
    chk(tag, "req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) chk(tag, "imem_addr", 32'(imem_addr), 32'(e_addr));
    chk(tag, "id_valid", 32'(id_valid), 32'(e_idv));
    if (e_idv) begin
      chk(tag, "id_pc", 32'(id_pc), 32'(e_idpc));
      chk(tag, "id_instr", 32'(id_instr), 32'(e_instr));
    end
    chk(tag, "pc", 32'(pc), 32'(e_pc));
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_fly = 1'b0; m_stale = 1'b0; m_slot = 1'b0;
    m_pc = 8'h00; m_fly_addr = 8'h00; m_slot_pc = 8'h00; m_slot_instr = 16'h0000;
    exp_fetch = 0; exp_disc = 0;
  endtask

  task automatic model_step(input logic rst, input logic h, input logic rv, input logic [7:0] rpc,
                            input logic rdy, input logic rsp, input logic [15:0] dat, input logic idr);
    logic [7:0] n_pc;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_slot && idr && exp_fetch < 65535) exp_fetch++;
    n_pc = rv ? rpc : ((m_req && rdy) ? m_pc + 8'd1 : m_pc);
    if (m_req) begin
      if (rdy) begin
        m_req = 1'b0; m_fly = 1'b1; m_fly_addr = m_pc; m_stale = rv;
      end
    end else if (m_fly) begin
      if (rsp) begin
        m_fly = 1'b0;
        if (m_stale || rv) begin
          m_stale = 1'b0;
          m_req = !h;
          if (exp_disc < 65535) exp_disc++;
        end else begin
          m_slot = 1'b1; m_slot_pc = m_fly_addr; m_slot_instr = dat;
        end
      end else if (rv) begin
        m_stale = 1'b1;
      end
    end else if (m_slot) begin
      if (rv || idr) begin
        m_slot = 1'b0;
        m_req = !h;
      end
    end else begin
      m_req = !h;
    end
    m_pc = n_pc;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 16'h0000, 0);
    tick();
    tick();
    expect_out("reset", 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h00);
    chk("reset", "imem_addr", 32'(imem_addr), 32'h00);
    chk("reset", "id_pc", 32'(id_pc), 32'h00);
    chk("reset", "id_instr", 32'(id_instr), 32'h0000);
    reset = 1'b0;

    // Straight-line fetch of 00, 01, 02 with always-ready memory and 1-cycle responses.
    vt[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000,         8'h00};
    vt[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000,         8'h01};
    vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, mem_word(8'h00), 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, mem_word(8'h00), 8'h01};
    vt[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000,         8'h01};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000,         8'h02};
    vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, mem_word(8'h01), 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, mem_word(8'h01), 8'h02};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 16'h0000,         8'h02};
    vt[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000,         8'h03};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, mem_word(8'h02), 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, mem_word(8'h02), 8'h03};
    vt[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000,         1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 16'h0000,         8'h03};

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].halt, vt[i].rv, vt[i].rpc, vt[i].rdy, vt[i].rsp, vt[i].data, vt[i].idr);
      tick();
      expect_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_idv,
                 vt[i].e_idpc, vt[i].e_instr, vt[i].e_pc);
    end

    // PC wrap: fetch at FF, next request at 00.
    drive(0, 1, 8'hFF, 0, 0, 16'h0, 0); tick();
    expect_out("wrap_redir", 1, 8'hFF, 0, 8'h00, 16'h0, 8'hFF);
    drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    expect_out("wrap_acc", 0, 8'h00, 0, 8'h00, 16'h0, 8'h00);
    drive(0, 0, 8'h00, 0, 1, mem_word(8'hFF), 0); tick();
    expect_out("wrap_rsp", 0, 8'h00, 1, 8'hFF, mem_word(8'hFF), 8'h00);
    drive(0, 0, 8'h00, 0, 0, 16'h0, 1); tick();
    expect_out("wrap_next", 1, 8'h00, 0, 8'h00, 16'h0, 8'h00);

    // Redirect to 40 while the request for 05 is outstanding.
    drive(0, 1, 8'h05, 0, 0, 16'h0, 0); tick();
    expect_out("wdis_req05", 1, 8'h05, 0, 8'h00, 16'h0, 8'h05);
    drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    expect_out("wdis_acc", 0, 8'h00, 0, 8'h00, 16'h0, 8'h06);
    drive(0, 1, 8'h40, 0, 0, 16'h0, 0); tick();
    expect_out("wdis_redir", 0, 8'h00, 0, 8'h00, 16'h0, 8'h40);
    drive(0, 0, 8'h00, 0, 1, mem_word(8'h05), 0); tick();
    expect_out("wdis_drop", 1, 8'h40, 0, 8'h00, 16'h0, 8'h40);

    // Decode stalls 5 cycles in HOLD.
    drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    drive(0, 0, 8'h00, 1, 1, mem_word(8'h40), 0); tick();
    expect_out("hold_cap", 0, 8'h00, 1, 8'h40, mem_word(8'h40), 8'h41);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
      expect_out($sformatf("hold_stall%0d", i), 0, 8'h00, 1, 8'h40, mem_word(8'h40), 8'h41);
    end
    drive(0, 0, 8'h00, 1, 0, 16'h0, 1); tick();
    expect_out("hold_rel", 1, 8'h41, 0, 8'h00, 16'h0, 8'h41);

    // Redirect to 80 in the cycle address 10 is accepted.
    drive(0, 1, 8'h10, 0, 0, 16'h0, 0); tick();
    expect_out("racc_req10", 1, 8'h10, 0, 8'h00, 16'h0, 8'h10);
    drive(0, 1, 8'h80, 1, 0, 16'h0, 0); tick();
    expect_out("racc_acc", 0, 8'h00, 0, 8'h00, 16'h0, 8'h80);
    drive(0, 0, 8'h00, 0, 1, mem_word(8'h10), 0); tick();
    expect_out("racc_drop", 1, 8'h80, 0, 8'h00, 16'h0, 8'h80);

    // Halt while holding: instruction still delivered, then idle until halt drops.
    drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    drive(0, 0, 8'h00, 0, 1, mem_word(8'h80), 0); tick();
    expect_out("halt_cap", 0, 8'h00, 1, 8'h80, mem_word(8'h80), 8'h81);
    drive(1, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    expect_out("halt_keep", 0, 8'h00, 1, 8'h80, mem_word(8'h80), 8'h81);
    drive(1, 0, 8'h00, 1, 0, 16'h0, 1); tick();
    expect_out("halt_idle", 0, 8'h00, 0, 8'h00, 16'h0, 8'h81);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h00, 1, 0, 16'h0, 0); tick();
      expect_out($sformatf("halt_wait%0d", i), 0, 8'h00, 0, 8'h00, 16'h0, 8'h81);
    end
    drive(0, 0, 8'h00, 0, 0, 16'h0, 0); tick();
    expect_out("halt_resume", 1, 8'h81, 0, 8'h00, 16'h0, 8'h81);

    // Reset in WAIT; the pre-reset response later arrives outside WAIT and is ignored.
    drive(0, 0, 8'h00, 1, 0, 16'h0, 0); tick();
    expect_out("rst_wait", 0, 8'h00, 0, 8'h00, 16'h0, 8'h82);
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 16'h0, 0); tick();
    reset = 1'b0;
    expect_out("rst_clear", 0, 8'h00, 0, 8'h00, 16'h0, 8'h00);
    drive(1, 0, 8'h00, 0, 1, mem_word(8'h81), 0); tick();
    expect_out("rst_stale_idle", 0, 8'h00, 0, 8'h00, 16'h0, 8'h00);
    drive(0, 0, 8'h00, 0, 0, 16'h0, 0); tick();
    expect_out("rst_req", 1, 8'h00, 0, 8'h00, 16'h0, 8'h00);
    drive(0, 0, 8'h00, 0, 1, mem_word(8'h81), 0); tick();
    expect_out("rst_stale_req", 1, 8'h00, 0, 8'h00, 16'h0, 8'h00);

    // Random traffic against the reference model.
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 16'h0, 0);
    tick();
    reset = 1'b0;
    model_reset();
    mem_pend = 1'b0;
    mem_addr = 8'h00;
    for (int c = 0; c < 800; c++) begin
      logic        r_rst, r_h, r_rv, r_rdy, r_rsp, r_idr;
      logic [7:0]  r_rpc;
      logic [15:0] r_dat;
      r_rst = ($urandom_range(0, 63) == 0);
      r_h   = ($urandom_range(0, 9) == 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_rpc = 8'($urandom);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_idr = ($urandom_range(0, 2) != 0);
      if (mem_pend) begin
        r_rsp = 1'($urandom_range(0, 1));
        r_dat = mem_word(mem_addr);
      end else begin
        r_rsp = ($urandom_range(0, 7) == 0);
        r_dat = 16'($urandom);
      end
      reset = r_rst;
      drive(r_h, r_rv, r_rpc, r_rdy, r_rsp, r_dat, r_idr);
      if (r_rst) begin
        mem_pend = 1'b0;
      end else begin
        if (mem_pend && r_rsp) mem_pend = 1'b0;
        if (m_req && r_rdy) begin
          mem_pend = 1'b1;
          mem_addr = m_pc;
        end
      end
      model_step(r_rst, r_h, r_rv, r_rpc, r_rdy, r_rsp, r_dat, r_idr);
      tick();
      expect_out($sformatf("rand%0d", c), m_req, m_pc, m_slot, m_slot_pc, m_slot_instr, m_pc);
    end
    reset = 1'b0;

`ifdef FETCH_PERF_EN
    chk("perf", "fetch_count", 32'(fetch_count), 32'(exp_fetch));
    chk("perf", "discard_count", 32'(discard_count), 32'(exp_disc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
